// File: rtl/sbus_rx_pkg.sv
// Shared types, default widths and elaboration helpers for the burst receive port.
package sbus_rx_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BURST_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ISSUE,
    WAIT_HS,
    DATA,
    WAIT_RDY
  } state_e;

  typedef enum logic [1:0] {
    CMD_RD,
    CMD_WR,
    CMD_ERR
  } cmd_e;

  // Exactly one enable must be set; anything else is a protocol error.
  function automatic cmd_e decode_cmd(input logic rd, input logic wr);
    if (rd && !wr) return CMD_RD;
    if (wr && !rd) return CMD_WR;
    return CMD_ERR;
  endfunction

  // Data frame must fit inside the address frame (data bits ride alongside).
  function automatic bit data_w_legal(input int dw, input int aw);
    return (dw >= 2) && (dw <= aw);
  endfunction

endpackage

// File: rtl/sbus_rx_port_sipo.sv
// Serial-in/parallel-out register: load clears and writes bit 0, shift writes bit idx.
module sbus_sipo #(
  parameter int W  = 8,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [IW-1:0] idx,
  input  logic          din,
  output logic [W-1:0]  q
);

  // Load starts a fresh frame; shift deposits one bit at its index.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q    <= '0;
      q[0] <= din;
    end else if (shift) begin
      for (int i = 0; i < W; i++)
        if (idx == IW'(i)) q[i] <= din;
    end
  end

endmodule

// File: rtl/slave_rx_port_burst.sv
// Serial-bus slave receive port with bursts, address wrap and read flow control.
module slave_rx_port_burst
  import sbus_rx_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_valid,
  input  logic               rx_address,
  input  logic               rx_data,
  input  logic               read_enable,
  input  logic               write_enable,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               m_ready,
  output logic               s_ready,
  output logic               rd_en,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [BURST_W-1:0] beat_cnt,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(ADDR_W + 1);

  if (!data_w_legal(DATA_W, ADDR_W)) begin : g_bad_data_w
    $error("slave_rx_port_burst: DATA_W must satisfy 2 <= DATA_W <= ADDR_W");
  end

  state_e             state, nxt;
  cmd_e               cmd_q;
  logic [BURST_W-1:0] blen_q;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_base;
  logic               hs, a_load, a_shift, d_load, d_shift;

  assign hs = m_valid & s_ready;

  // Frame deserialisers; the data register also refills on continuation beats.
  assign a_load  = (state == IDLE) && hs;
  assign a_shift = (state == ADDR);
  assign d_load  = hs;
  assign d_shift = ((state == ADDR) && (cnt < CNT_W'(DATA_W))) || (state == DATA);

  sbus_sipo #(.W(ADDR_W), .IW(CNT_W)) u_addr_sipo (
    .clk(clk), .rst(rst), .load(a_load), .shift(a_shift),
    .idx(cnt), .din(rx_address), .q(addr_base)
  );

  sbus_sipo #(.W(DATA_W), .IW(CNT_W)) u_data_sipo (
    .clk(clk), .rst(rst), .load(d_load), .shift(d_shift),
    .idx(cnt), .din(rx_data), .q(data_out)
  );

  // Beat k of a burst sits at base + k; truncation gives the all-ones -> 0 wrap.
  assign addr_out = addr_base + ADDR_W'(beat_cnt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    nxt     = state;
    s_ready = 1'b0;
    busy    = 1'b1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (hs) nxt = ADDR;
      end
      ADDR: if (cnt == CNT_W'(ADDR_W - 1)) nxt = ISSUE;
      ISSUE: begin
        rd_en = (cmd_q == CMD_RD);
        wr_en = (cmd_q == CMD_WR);
        err   = (cmd_q == CMD_ERR);
        if (cmd_q == CMD_ERR || beat_cnt == blen_q) nxt = IDLE;
        else if (cmd_q == CMD_WR)                     nxt = WAIT_HS;
        else                                          nxt = WAIT_RDY;
      end
      WAIT_HS: begin
        s_ready = 1'b1;
        if (hs) nxt = DATA;
      end
      DATA:     if (cnt == CNT_W'(DATA_W - 1)) nxt = ISSUE;
      WAIT_RDY: if (m_ready) nxt = ISSUE;
      default:  nxt = IDLE;
    endcase
  end

  // Bit counter, latched command/length and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cmd_q    <= CMD_ERR;
      blen_q   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          cnt      <= CNT_W'(1);
          cmd_q    <= decode_cmd(read_enable, write_enable);
          blen_q   <= burst_len;
          beat_cnt <= '0;
        end
        ADDR, DATA: cnt <= cnt + 1'b1;
        ISSUE:   if (cmd_q != CMD_ERR) beat_cnt <= beat_cnt + 1'b1;
        WAIT_HS: if (hs) cnt <= CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_rx_port_burst.sv
// Directed bench for slave_rx_port_burst with hand-computed expectations.
module tb_slave_rx_port_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, rx_address, rx_data, read_enable, write_enable, m_ready;
  logic [11:0] burst_len;
  logic        s_ready, rd_en, wr_en, busy, err;
  logic [11:0] addr_out;
  logic [7:0]  data_out;
  logic [11:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  slave_rx_port_burst dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .rx_address(rx_address),
    .rx_data(rx_data), .read_enable(read_enable), .write_enable(write_enable),
    .burst_len(burst_len), .m_ready(m_ready), .s_ready(s_ready),
    .rd_en(rd_en), .wr_en(wr_en), .addr_out(addr_out), .data_out(data_out),
    .beat_cnt(beat_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake in the current cycle (cycle 0), then address bits 1..11; returns in cycle 12.
  // Command inputs are scrambled after the handshake to show they are ignored.
  task automatic send_frame(input logic [11:0] a, input logic [7:0] d,
                            input logic rd, input logic wr, input logic [11:0] bl);
    m_valid = 1'b1; rx_address = a[0]; rx_data = d[0];
    read_enable = rd; write_enable = wr; burst_len = bl;
    for (int i = 1; i < 12; i++) begin
      tick();
      m_valid = 1'b0; read_enable = 1'b0; write_enable = 1'b0; burst_len = '1;
      rx_address = a[i];
      rx_data = (i < 8) ? d[i % 8] : 1'b0;
    end
    chk("no_strobe_cycle11", 32'({rd_en, wr_en, err}), 32'h0);
    tick();
  endtask

  // Continuation data beat from WAIT_HS; returns in the ISSUE cycle (cycle 8).
  task automatic send_data(input logic [7:0] d);
    m_valid = 1'b1; rx_data = d[0];
    for (int i = 1; i < 8; i++) begin
      tick();
      m_valid = 1'b0; rx_data = d[i];
      if (i == 1) chk("s_ready_low_in_data", 32'(s_ready), 32'h0);
    end
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, 32'({s_ready, busy, rd_en, wr_en, err}), 32'b10000);
    chk({tag, "_addr"}, 32'(addr_out), 32'h0);
    chk({tag, "_data"}, 32'(data_out), 32'h0);
    chk({tag, "_beat"}, 32'(beat_cnt), 32'h0);
  endtask

  initial begin
    rst = 1'b1; m_valid = 1'b0; rx_address = 1'b0; rx_data = 1'b0;
    read_enable = 1'b0; write_enable = 1'b0; burst_len = '0; m_ready = 1'b1;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single write.
    send_frame(12'h5A3, 8'hC7, 1'b0, 1'b1, 12'd0);
    chk("sw_wr_en", 32'({rd_en, wr_en}), 32'b01);
    chk("sw_addr", 32'(addr_out), 32'h5A3);
    chk("sw_data", 32'(data_out), 32'hC7);
    chk("sw_busy_sready", 32'({busy, s_ready}), 32'b10);
    tick();
    chk("sw_after", 32'({wr_en, s_ready, busy}), 32'b010);
    chk("sw_beat_cnt", 32'(beat_cnt), 32'd1);

    // Single read.
    send_frame(12'h010, 8'h00, 1'b1, 1'b0, 12'd0);
    chk("sr_strobes", 32'({rd_en, wr_en}), 32'b10);
    chk("sr_addr", 32'(addr_out), 32'h010);
    tick();
    chk("sr_after", 32'({rd_en, wr_en, busy, s_ready}), 32'b0001);

    // Write burst wrapping through all-ones.
    send_frame(12'hFFF, 8'h11, 1'b0, 1'b1, 12'd2);
    chk("wb0_strobe", 32'({rd_en, wr_en}), 32'b01);
    chk("wb0_addr_data", {8'h0, addr_out, 4'h0, data_out}, {8'h0, 12'hFFF, 4'h0, 8'h11});
    tick();
    chk("wb_wait_hs", 32'({s_ready, busy, wr_en}), 32'b110);
    chk("wb_beat1", 32'(beat_cnt), 32'd1);
    send_data(8'h22);
    chk("wb1_strobe", 32'({rd_en, wr_en}), 32'b01);
    chk("wb1_addr_data", {8'h0, addr_out, 4'h0, data_out}, {8'h0, 12'h000, 4'h0, 8'h22});
    tick();
    send_data(8'h33);
    chk("wb2_strobe", 32'({rd_en, wr_en}), 32'b01);
    chk("wb2_addr_data", {8'h0, addr_out, 4'h0, data_out}, {8'h0, 12'h001, 4'h0, 8'h33});
    tick();
    chk("wb_end", 32'({s_ready, busy, wr_en}), 32'b100);
    chk("wb_beat_cnt", 32'(beat_cnt), 32'd3);

    // Read burst with m_ready backpressure.
    m_ready = 1'b0;
    send_frame(12'h100, 8'h00, 1'b1, 1'b0, 12'd1);
    chk("rb0_strobe", 32'({rd_en, wr_en}), 32'b10);
    chk("rb0_addr", 32'(addr_out), 32'h100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rb_hold", 32'({rd_en, wr_en, s_ready, busy}), 32'b0001);
    end
    m_ready = 1'b1;
    tick();
    chk("rb1_strobe", 32'({rd_en, wr_en}), 32'b10);
    chk("rb1_addr", 32'(addr_out), 32'h101);
    tick();
    chk("rb_end", 32'({rd_en, busy, s_ready}), 32'b001);
    chk("rb_beat_cnt", 32'(beat_cnt), 32'd2);

    // Illegal command: both enables.
    send_frame(12'h3C5, 8'h00, 1'b1, 1'b1, 12'd0);
    chk("ill_err", 32'({err, rd_en, wr_en}), 32'b100);
    tick();
    chk("ill_after", 32'({err, s_ready, busy}), 32'b010);

    // Reset in the middle of an address frame (at bit 6).
    m_valid = 1'b1; rx_address = 1'b1; rx_data = 1'b1;
    read_enable = 1'b0; write_enable = 1'b1; burst_len = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      m_valid = 1'b0; rx_address = 1'b1; rx_data = 1'b1;
    end
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();
    chk("midrst_idle_no_strobe", 32'({rd_en, wr_en, s_ready}), 32'b001);
    send_frame(12'h0AB, 8'h5C, 1'b0, 1'b1, 12'd0);
    chk("post_rst_strobe", 32'({rd_en, wr_en}), 32'b01);
    chk("post_rst_addr_data", {8'h0, addr_out, 4'h0, data_out}, {8'h0, 12'h0AB, 4'h0, 8'h5C});
    tick();
    chk("post_rst_end", 32'({s_ready, busy}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slave_rx_port_burst.md
Name: slave_rx_port_burst

Overview:
- Parametrised successor to the serial-bus slave receive port.
- Deserialises LSB-first address and write-data frames from the master after an m_valid/s_ready handshake.
- Issues one-cycle read or write strobes to the slave memory side.
- Adds multi-beat bursts with address auto-increment and wrap, read-burst flow control on m_ready, and protocol-error reporting.

Parameters:
ADDR_W, 12, address width in bits (serial address frame length)
DATA_W, 8, data width in bits; legal range 2 <= DATA_W <= ADDR_W
BURST_W, 12, width of burst beat count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m_valid  in  1  master frame/beat valid
rx_address  in  1  serial address bit, LSB first
rx_data  in  1  serial write-data bit, LSB first
read_enable  in  1  read command, sampled at first handshake
write_enable  in  1  write command, sampled at first handshake
burst_len  in  BURST_W  beats minus 1, sampled at first handshake
m_ready  in  1  master ready for next read beat
s_ready  out  1  slave ready for handshake
rd_en  out  1  one-cycle read strobe
wr_en  out  1  one-cycle write strobe
addr_out  out  ADDR_W  beat address, valid with strobe
data_out  out  DATA_W  write data, valid with wr_en
beat_cnt  out  BURST_W  beats issued in current transaction
busy  out  1  transaction in progress
err  out  1  one-cycle pulse on illegal command

Behaviour:
- Reset (synchronous, any state):
  - state IDLE; addr_out, data_out, beat_cnt = 0.
  - rd_en, wr_en, err, busy = 0; s_ready = 1.
  - An in-flight frame is dropped and no strobe is issued.
- Handshake = m_valid & s_ready.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- s_ready = 1 in IDLE and WAIT_HS only.
- busy = 1 in every state other than IDLE.
- IDLE:
  - On handshake: capture rx_address into addr bit 0 and rx_data into data bit 0; latch cmd and burst_len; clear beat_cnt; bit counter = 1; go to ADDR.
- ADDR:
  - Each cycle, shift rx_address into addr[cnt].
  - When cnt < DATA_W, also shift rx_data into data[cnt].
  - When cnt == ADDR_W-1, capture the last bit and go to ISSUE.
  - m_valid is ignored during ADDR.
- ISSUE (exactly one cycle):
  - Assert wr_en (write) or rd_en (read); addr_out/data_out hold the beat values.
  - beat_cnt increments at the end of the cycle.
  - Illegal cmd (both enables or neither) gives no strobe: err = 1, go to IDLE.
  - If beat_cnt == latched burst_len, go to IDLE.
  - Otherwise addr += 1, modulo 2^ADDR_W (0 follows all-ones), and go to WAIT_HS for a write or WAIT_RDY for a read.
- WAIT_HS (write burst):
  - On handshake: capture data bit 0; cnt = 1; go to DATA.
  - No address bits are sent for continuation beats.
- DATA:
  - Shift rx_data into data[cnt].
  - At cnt == DATA_W-1, go to ISSUE.
- WAIT_RDY (read burst):
  - s_ready = 0.
  - When m_ready = 1, go to ISSUE; otherwise hold indefinitely.
- Latency: first strobe ADDR_W cycles after the handshake cycle (handshake = cycle 0). Write-burst continuation strobes come DATA_W cycles after each handshake.
- read_enable/write_enable/burst_len changes after the first handshake are ignored.
- Strobes never coincide: rd_en & wr_en = 0 always.

Decomposition:
- Package sbus_rx_pkg:
  - state enum (IDLE, ADDR, ISSUE, WAIT_HS, DATA, WAIT_RDY)
  - cmd enum (CMD_RD, CMD_WR, CMD_ERR)
  - default width constants
  - elaboration-time check of DATA_W range
- Sub-module sbus_sipo: parametrised serial-in/parallel-out register with load-bit-0, shift-enable and bit-index inputs. Instanced twice, for address (ADDR_W) and data (DATA_W).

Test Plan:
- Single write: handshake, addr 0x5A3, data 0xC7, burst_len 0 -> wr_en high exactly at cycle 12 with addr_out 0x5A3, data_out 0xC7; then s_ready = 1, busy = 0, beat_cnt = 1.
- Single read: addr 0x010, read_enable, burst_len 0 -> rd_en one cycle at cycle 12 with addr_out 0x010; wr_en never asserted.
- Write burst with wrap: addr 0xFFF, burst_len 2, data 0x11/0x22/0x33 -> wr_en three times with (0xFFF, 0x11), (0x000, 0x22), (0x001, 0x33); s_ready high only in IDLE/WAIT_HS gaps; beat_cnt ends at 3.
- Read burst with backpressure: addr 0x100, burst_len 1, m_ready low 5 cycles after first strobe -> rd_en at 0x100, no strobe for 5 cycles, rd_en at 0x101 one cycle after m_ready rises.
- Illegal command: read_enable = write_enable = 1 -> full 12-bit frame absorbed, err pulse at cycle 12, no rd_en/wr_en, s_ready = 1 next cycle.
- Reset mid-frame: rst asserted at address bit 6 -> next cycle all outputs at reset values; no strobe; new write frame afterwards completes normally.
